ps2_host_tx: RTL and testbench

- Host-to-device transmitter for the PS/2 keyboard port; the send direction paired with the existing keyboard scan/receive path.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset), following the PS/2 request-to-send protocol.
- Sits between the CPU MMIO keyboard register block and the open-drain PS/2 pads.
- While `busy=1`, the receive path ignores the lines.

---
 rtl/ps2_host_tx.sv | 190 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned INHIBIT_US  = 120,
  parameter int unsigned REQ_CYCLES  = 16,
  parameter int unsigned TIMEOUT_US  = 20000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // Microsecond figures converted to clk cycles in 64 bits to avoid overflow at high clk rates.
  localparam logic [63:0] INH_PROD = 64'(INHIBIT_US) * 64'(CLK_FREQ_HZ) / 64'd1000000;
  localparam logic [63:0] TO_PROD  = 64'(TIMEOUT_US) * 64'(CLK_FREQ_HZ) / 64'd1000000;
  localparam logic [31:0] INH_CYC  = INH_PROD[31:0];
  localparam logic [31:0] TO_CYC   = TO_PROD[31:0];
  localparam logic [31:0] REQ_CYC  = REQ_CYCLES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  logic [1:0]  clk_sync;
  logic [1:0]  data_sync;
  logic [1:0]  tick_cnt;
  logic [7:0]  clk_shf;
  logic [7:0]  data_shf;
  logic        clk_f;
  logic        data_f;
  logic        clk_f_d;
  logic        fall;

  state_t      state;
  logic [8:0]  shreg;
  logic [3:0]  bit_n;
  logic [31:0] phase_cnt;
  logic [31:0] to_cnt;

  assign fall = clk_f_d & ~clk_f;

  // Pad synchronizers and 8-sample glitch filters; filtered levels idle high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      tick_cnt  <= 2'd0;
      clk_shf   <= 8'hFF;
      data_shf  <= 8'hFF;
      clk_f     <= 1'b1;
      data_f    <= 1'b1;
      clk_f_d   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      tick_cnt  <= tick_cnt + 2'd1;
      clk_f_d   <= clk_f;
      if (tick_cnt == 2'd3) begin
        clk_shf  <= {clk_shf[6:0], clk_sync[1]};
        data_shf <= {data_shf[6:0], data_sync[1]};
        if ({clk_shf[6:0], clk_sync[1]} == 8'hFF) begin
          clk_f <= 1'b1;
        end else if ({clk_shf[6:0], clk_sync[1]} == 8'h00) begin
          clk_f <= 1'b0;
        end
        if ({data_shf[6:0], data_sync[1]} == 8'hFF) begin
          data_f <= 1'b1;
        end else if ({data_shf[6:0], data_sync[1]} == 8'h00) begin
          data_f <= 1'b0;
        end
      end
    end
  end

  // Request-to-send sequencer: inhibit, start bit, bit shifting on device clock, ACK check, timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      shreg       <= 9'd0;
      bit_n       <= 4'd0;
      phase_cnt   <= 32'd0;
      to_cnt      <= 32'd0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == S_IDLE) begin
        if (tx_valid && tx_ready) begin
          shreg       <= {~^tx_data, tx_data};
          state       <= S_INHIBIT;
          tx_ready    <= 1'b0;
          busy        <= 1'b1;
          ps2_clk_oe  <= 1'b1;
          ps2_data_oe <= 1'b0;
          phase_cnt   <= 32'd0;
          to_cnt      <= 32'd0;
          bit_n       <= 4'd0;
        end
      end else if (to_cnt == TO_CYC - 32'd1) begin
        // Timeout wins over any fall/done seen in the same cycle.
        err         <= 1'b1;
        state       <= S_IDLE;
        tx_ready    <= 1'b1;
        busy        <= 1'b0;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
      end else begin
        to_cnt <= to_cnt + 32'd1;
        case (state)
          S_INHIBIT: begin
            if (phase_cnt == INH_CYC - 32'd1) begin
              phase_cnt   <= 32'd0;
              ps2_data_oe <= 1'b1;
              state       <= S_REQ;
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end
          S_REQ: begin
            if (phase_cnt == REQ_CYC - 32'd1) begin
              ps2_clk_oe <= 1'b0;
              bit_n      <= 4'd0;
              state      <= S_SEND;
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end
          S_SEND: begin
            if (fall) begin
              if (bit_n == 4'd9) begin
                ps2_data_oe <= 1'b0;
                state       <= S_ACK;
              end else begin
                ps2_data_oe <= ~shreg[bit_n];
                bit_n       <= bit_n + 4'd1;
              end
            end
          end
          S_ACK: begin
            if (fall) begin
              if (!data_f) begin
                state <= S_WAIT_IDLE;
              end else begin
                err      <= 1'b1;
                state    <= S_IDLE;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (clk_f && data_f) begin
              done     <= 1'b1;
              state    <= S_IDLE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
          default: begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 keyboard device model
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_MHZ = 4;
  localparam int INH_EXP = 120 * CLK_MHZ;
  localparam int TO_EXP  = 5000 * CLK_MHZ;
  localparam int US      = 1000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_i, ps2_data_i;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int n_chk = 0, n_pass = 0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ(CLK_MHZ * 1000000),
    .INHIBIT_US (120),
    .REQ_CYCLES (16),
    .TIMEOUT_US (5000)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #125 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
    if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Wire-level frame the device should see: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_oe(input bit which, input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if ((which ? ps2_data_oe : ps2_clk_oe) === val) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_end(input int budget, output bit got_done, output bit got_err, output int lat);
    got_done = 1'b0;
    got_err  = 1'b0;
    lat      = 0;
    for (int i = 0; i < budget && !got_done && !got_err; i++) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) got_done = 1'b1;
      if (err === 1'b1) got_err = 1'b1;
    end
  endtask

  // Keyboard model: waits for the request to send, clocks in 11 bits at 40 us period, then ACKs.
  task automatic device(input bit ack_low, input int abort_at, input bit jig,
                        output logic [10:0] frame, output int inh_cycles, output bit ok);
    int c0;
    bit w;
    frame = '1;
    inh_cycles = 0;
    ok = 1'b1;
    wait_oe(1'b0, 1'b1, 50, w);
    ok &= w;
    c0 = cyc;
    wait_oe(1'b1, 1'b1, 4 * INH_EXP, w);
    ok &= w;
    inh_cycles = cyc - c0;
    wait_oe(1'b0, 1'b0, 200, w);
    ok &= w;
    if (!ok) return;
    #(50 * US);
    frame[0] = ps2_data_i;
    for (int i = 1; i <= 10; i++) begin
      if (jig) tx_data = 8'($urandom);
      dev_clk_low = 1'b1;
      if (i == abort_at) begin
        #(15 * US);
        return;
      end
      #(20 * US);
      dev_clk_low = 1'b0;
      frame[i] = ps2_data_i;
      if (i == 10) #(15 * US);
      else #(20 * US);
    end
    dev_data_low = ack_low;
    #(5 * US);
    dev_clk_low = 1'b1;
    #(20 * US);
    dev_clk_low = 1'b0;
    #(20 * US);
    dev_data_low = 1'b0;
  endtask

  task automatic accept(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic do_send(input logic [7:0] b, input bit ack_low, input string tag);
    logic [10:0] fr;
    int inh, lat, d0, e0;
    bit ok, gd, ge;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(b);
    device(ack_low, 0, 1'b0, fr, inh, ok);
    chk({tag, "_dev_ok"}, 32'(ok), 32'd1);
    chk({tag, "_inhibit_ge_120us"}, 32'(inh >= INH_EXP), 32'd1);
    chk({tag, "_frame"}, 32'(fr), 32'(exp_frame(b)));
    wait_end(400, gd, ge, lat);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), ack_low ? 32'd1 : 32'd0);
    chk({tag, "_err_pulses"}, 32'(err_cnt - e0), ack_low ? 32'd0 : 32'd1);
    chk({tag, "_idle_outputs"}, {28'd0, busy, tx_ready, ps2_clk_oe, ps2_data_oe}, 32'b0100);
  endtask

  initial begin
    logic [7:0] b1, b2;
    logic [10:0] fr;
    int inh, lat, d0, e0;
    bit ok, gd, ge;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Reset during data bit 3, then a clean 0x55
    b1 = 8'($urandom) & 8'hF7;
    d0 = done_cnt;
    e0 = err_cnt;
    accept(b1);
    device(1'b1, 4, 1'b0, fr, inh, ok);
    chk("t1_dev_ok", 32'(ok), 32'd1);
    chk("t1_bit3_driven_low", 32'(ps2_data_oe), 32'd1);
    #100;
    rstn = 1'b0;
    #1;
    chk("t1_rst_oe_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("t1_rst_tx_ready", 32'(tx_ready), 32'd1);
    dev_clk_low = 1'b0;
    repeat (40) @(negedge clk);
    chk("t1_no_done_err", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    do_send(8'h55, 1'b1, "t1_0x55");

    // Directed bytes: set-LEDs and parity extremes
    do_send(8'hED, 1'b1, "t2_0xED");
    do_send(8'h00, 1'b1, "t3_0x00");
    do_send(8'hFF, 1'b1, "t3_0xFF");

    // Random bytes
    for (int k = 0; k < 3; k++) do_send(8'($urandom), 1'b1, "rand");

    // Device never clocks
    e0 = err_cnt;
    d0 = done_cnt;
    accept(8'($urandom));
    wait_end(TO_EXP + 200, gd, ge, lat);
    chk("t4_err_seen", 32'(ge), 32'd1);
    chk("t4_no_done", 32'(gd), 32'd0);
    chk("t4_timeout_latency", 32'(lat >= TO_EXP - 1 && lat <= TO_EXP + 1), 32'd1);
    chk("t4_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("t4_tx_ready", 32'(tx_ready), 32'd1);
    repeat (100) @(negedge clk);
    chk("t4_single_err", 32'(err_cnt - e0), 32'd1);
    chk("t4_done_count", 32'(done_cnt - d0), 32'd0);

    // Missing ACK
    do_send(8'($urandom), 1'b0, "t5_noack");

    // tx_valid held through transfers with changing tx_data
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    d0 = done_cnt;
    @(negedge clk);
    tx_data  = b1;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("t6_first_accept", {30'd0, busy, tx_ready}, 32'b10);
    tx_data = ~b1;
    device(1'b1, 0, 1'b1, fr, inh, ok);
    chk("t6_dev1_ok", 32'(ok), 32'd1);
    chk("t6_inhibit_ge_120us", 32'(inh >= INH_EXP), 32'd1);
    chk("t6_frame1", 32'(fr), 32'(exp_frame(b1)));
    wait_end(400, gd, ge, lat);
    chk("t6_done1", 32'(gd), 32'd1);
    chk("t6_ready_in_done_cycle", 32'(tx_ready), 32'd1);
    tx_data = b2;
    @(negedge clk);
    chk("t6_second_accept", {30'd0, busy, tx_ready}, 32'b10);
    device(1'b1, 0, 1'b1, fr, inh, ok);
    chk("t6_dev2_ok", 32'(ok), 32'd1);
    chk("t6_frame2", 32'(fr), 32'(exp_frame(b2)));
    wait_end(400, gd, ge, lat);
    chk("t6_done2", 32'(gd), 32'd1);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("t6_idle_after", {30'd0, busy, tx_ready}, 32'b01);

    chk("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
